// File: rtl/imem_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_if
// Purpose  : Fetch-side and ROM-side signal bundle for imem_server.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_if;
  logic        re_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        empty_o;

  modport slave (
    input  re_i, redirect_i, redirect_pc_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, instr_o, pc_o, empty_o
  );

  modport master (
    output re_i, redirect_i, redirect_pc_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, instr_o, pc_o, empty_o
  );
endinterface
`default_nettype wire

// File: rtl/imem_server.sv
`default_nettype none
// ============================================================================
// Module   : imem_server
// Purpose  : PC owner and prefetch FIFO in front of a 1-cycle-latency ROM.
// Revision : 1.0 - initial release
// ============================================================================
module imem_server #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  imem_if.slave  bus
);
  localparam int              c_AW    = $clog2(DEPTH);
  localparam logic [c_AW+1:0] c_DEPTH = (c_AW+2)'(DEPTH);
  localparam logic [c_AW:0]   c_ONE   = (c_AW+1)'(1);

  logic [31:0]   r_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic [c_AW:0] r_wr;
  logic [c_AW:0] r_rd;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_word [DEPTH];

  logic [c_AW:0]   w_count;
  logic [c_AW+1:0] w_used;
  logic            w_empty;
  logic            w_req;
  logic            w_pop;
  logic [c_AW-1:0] w_head;

  // Occupancy plus the outstanding read bounds requests, so a push always has room.
  always_comb begin
    w_count = r_wr - r_rd;
    w_used  = {1'b0, w_count} + {{(c_AW+1){1'b0}}, r_inflight};
    w_empty = (r_wr == r_rd);
    w_req   = !bus.redirect_i && (w_used < c_DEPTH);
    w_pop   = bus.re_i && !w_empty && !bus.redirect_i;
    w_head  = r_rd[c_AW-1:0];
  end

  assign bus.mem_req_o  = w_req;
  assign bus.mem_addr_o = r_pc;
  assign bus.empty_o    = w_empty;
  assign bus.instr_o    = w_empty ? 32'h0 : r_fifo_word[w_head];
  assign bus.pc_o       = w_empty ? 32'h0 : r_fifo_pc[w_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= 32'h0;
      r_inflight    <= 1'b0;
      r_wr          <= '0;
      r_rd          <= '0;
    end else if (bus.redirect_i) begin
      // Dropping inflight discards the response that lands next cycle.
      r_pc       <= bus.redirect_pc_i & 32'hFFFF_FFFC;
      r_inflight <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      if (w_req) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
      r_inflight <= w_req;
      if (r_inflight) r_wr <= r_wr + c_ONE;
      if (w_pop)      r_rd <= r_rd + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (r_inflight && !bus.redirect_i) begin
      r_fifo_pc[r_wr[c_AW-1:0]]   <= r_inflight_pc;
      r_fifo_word[r_wr[c_AW-1:0]] <= bus.mem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_inflight && !bus.redirect_i && !w_pop && (w_count == c_DEPTH[c_AW:0])));

endmodule
`default_nettype wire

// File: tb/tb_imem_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_server
// Purpose  : Self-checking bench for imem_server with a fetch-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_server;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
  localparam int          c_DEPTH    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_if bus();

  imem_server #(.RESET_PC(c_RESET_PC), .DEPTH(c_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_req    = 0;
  int n_pop    = 0;

  logic [63:0] sb_q[$];
  logic [31:0] sb_next;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic sb_top_up;
    while (sb_q.size() < 8) begin
      sb_q.push_back({sb_next, rom_word(sb_next)});
      sb_next = sb_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    sb_q.delete();
    sb_next = pc & 32'hFFFF_FFFC;
    sb_top_up();
  endtask

  // ROM: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_req_o) bus.mem_rdata_i <= rom_word(bus.mem_addr_o);
  end

  // Every consumed word must be the next one in program order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && bus.mem_req_o) n_req++;
    if (rst_n && bus.re_i && !bus.redirect_i && !bus.empty_o) begin
      n_pop++;
      sb_top_up();
      e = sb_q.pop_front();
      chk_eq("pop_pc", bus.pc_o, e[63:32]);
      chk_eq("pop_instr", bus.instr_o, e[31:0]);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_empty"}, {31'h0, bus.empty_o}, 32'h1);
    chk_eq({tag, "_instr"}, bus.instr_o, 32'h0);
    chk_eq({tag, "_pc"}, bus.pc_o, 32'h0);
  endtask

  // Leaves the caller at the start of the first cycle after release.
  task automatic do_reset;
    cyc();
    rst_n = 1'b0;
    bus.re_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    sb_restart(c_RESET_PC);
    #1;
    chk_idle_outputs("rst");
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc, input logic re);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = pc;
    bus.re_i = re;
    sb_restart(pc);
  endtask

  initial begin
    int base;
    bus.re_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.mem_rdata_i = 32'h0;

    // Sequential fetch from reset with re_i held high
    do_reset();
    bus.re_i = 1'b1;
    mid();
    chk_eq("c0_req", {31'h0, bus.mem_req_o}, 32'h1);
    chk_eq("c0_addr", bus.mem_addr_o, 32'h100);
    chk_idle_outputs("c0");
    cyc(); mid();
    chk_eq("c1_addr", bus.mem_addr_o, 32'h104);
    chk_eq("c1_empty", {31'h0, bus.empty_o}, 32'h1);
    cyc(); mid();
    chk_eq("c2_empty", {31'h0, bus.empty_o}, 32'h0);
    chk_eq("c2_pc", bus.pc_o, 32'h100);
    chk_eq("c2_addr", bus.mem_addr_o, 32'h108);
    repeat (6) begin
      cyc(); mid();
      chk_eq("steady_req", {31'h0, bus.mem_req_o}, 32'h1);
    end

    // Stalled fetch fills exactly DEPTH entries
    do_reset();
    base = n_req;
    repeat (10) begin mid(); cyc(); end
    chk_eq("stall_req_count", n_req - base, c_DEPTH);
    mid();
    chk_eq("stall_req_idle", {31'h0, bus.mem_req_o}, 32'h0);
    chk_eq("stall_empty", {31'h0, bus.empty_o}, 32'h0);
    chk_eq("stall_head_pc", bus.pc_o, 32'h100);
    chk_eq("stall_head_instr", bus.instr_o, rom_word(32'h100));
    cyc();
    bus.re_i = 1'b1;
    base = n_pop;
    repeat (8) cyc();
    chk_eq("drain_no_gaps", n_pop - base, 8);

    // Redirect while full with a read outstanding
    bus.re_i = 1'b0;
    repeat (6) cyc();
    bus.re_i = 1'b1;
    cyc();
    bus.re_i = 1'b0;
    cyc();
    redirect_to(32'h0000_2003, 1'b0);
    mid();
    chk_eq("redir_req_off", {31'h0, bus.mem_req_o}, 32'h0);
    cyc();
    bus.redirect_i = 1'b0;
    bus.re_i = 1'b1;
    mid();
    chk_eq("redir_req", {31'h0, bus.mem_req_o}, 32'h1);
    chk_eq("redir_addr", bus.mem_addr_o, 32'h2000);
    chk_eq("redir_r1_empty", {31'h0, bus.empty_o}, 32'h1);
    cyc(); mid();
    chk_eq("redir_r2_empty", {31'h0, bus.empty_o}, 32'h1);
    cyc(); mid();
    chk_eq("redir_r3_pc", bus.pc_o, 32'h2000);

    // Redirect and re_i together: no pop, FIFO empty afterwards
    repeat (4) cyc();
    redirect_to(32'h0000_3000, 1'b1);
    base = n_pop;
    mid();
    chk_eq("redir_re_nonempty", {31'h0, bus.empty_o}, 32'h0);
    cyc();
    bus.redirect_i = 1'b0;
    chk_eq("redir_re_no_pop", n_pop - base, 0);
    mid();
    chk_eq("redir_re_empty", {31'h0, bus.empty_o}, 32'h1);

    // PC wrap across the top of the address space
    repeat (5) cyc();
    redirect_to(32'hFFFF_FFF8, 1'b1);
    cyc();
    bus.redirect_i = 1'b0;
    cyc(); cyc(); mid();
    chk_eq("wrap_pc0", bus.pc_o, 32'hFFFF_FFF8);
    cyc(); mid();
    chk_eq("wrap_pc1", bus.pc_o, 32'hFFFF_FFFC);
    cyc(); mid();
    chk_eq("wrap_pc2", bus.pc_o, 32'h0000_0000);

    // One-cycle reset pulse mid-stream
    repeat (3) cyc();
    rst_n = 1'b0;
    sb_restart(c_RESET_PC);
    #1;
    chk_idle_outputs("midrst");
    cyc();
    rst_n = 1'b1;
    mid();
    chk_eq("midrst_req", {31'h0, bus.mem_req_o}, 32'h1);
    chk_eq("midrst_addr", bus.mem_addr_o, c_RESET_PC);
    cyc(); cyc(); mid();
    chk_eq("midrst_pc", bus.pc_o, c_RESET_PC);

    // Random stalls and redirects against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cyc();
      if ($urandom_range(0, 19) == 0) begin
        redirect_to($urandom(), ($urandom_range(0, 1) == 1));
      end else begin
        bus.redirect_i = 1'b0;
        bus.re_i = ($urandom_range(0, 3) != 0);
      end
    end
    cyc();
    bus.redirect_i = 1'b0;
    bus.re_i = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
